// File: rtl/wb_port_arbiter.sv
// ----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the register file's single write port between the in-order
//   pipeline write-back stage and the multi-cycle unit (div/mul/long load).
//   The pipeline normally wins. A starvation counter tracks lost cycles of a
//   pending multi-cycle write. When the limit is reached, the block forces a
//   one-cycle grant and stalls the pipeline for that cycle.
//
// Parameters
//   STARVE_LIMIT  consecutive lost cycles before a forced grant (1..15)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous, active-high reset
//   p_we       in   pipeline write request
//   p_waddr    in   pipeline destination register [4:0]
//   p_wdata    in   pipeline write data [31:0]
//   m_valid    in   multi-cycle write pending
//   m_waddr    in   multi-cycle destination register [4:0]
//   m_wdata    in   multi-cycle write data [31:0]
//   m_ready    out  multi-cycle write accepted (handshake completes)
//   stall_req  out  freeze the whole pipeline, including WB, this cycle
//   rf_we      out  register file write enable
//   rf_waddr   out  register file write address [4:0]
//   rf_wdata   out  register file write data [31:0]
// ----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_we,
    input  logic [4:0]  p_waddr,
    input  logic [31:0] p_wdata,
    input  logic        m_valid,
    input  logic [4:0]  m_waddr,
    input  logic [31:0] m_wdata,
    output logic        m_ready,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_FORCE = 1'b1
    } state_e;

    localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    state_e     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    // Combinational arbitration results before reset masking.
    logic sel_m;       // multi-cycle unit is the routed source
    logic route_we;    // some source is routed this cycle
    logic grant_m;     // handshake completes this cycle
    logic force_stall;
    logic routed_zero; // routed destination is x0, so the write is dropped

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARB;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        sel_m       = 1'b0;
        route_we    = 1'b0;
        grant_m     = 1'b0;
        force_stall = 1'b0;

        unique case (state_q)
            ST_ARB: begin
                if (p_we && !m_valid) begin
                    route_we = 1'b1;
                end else if (!p_we && m_valid) begin
                    sel_m      = 1'b1;
                    route_we   = 1'b1;
                    grant_m    = 1'b1;
                    wait_cnt_d = '0;
                end else if (p_we && m_valid) begin
                    route_we = 1'b1;
                    if (p_waddr == m_waddr) begin
                        // The younger pipeline write supersedes the multi-cycle
                        // result. The multi-cycle handshake completes and that
                        // result is dropped.
                        grant_m    = 1'b1;
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == LIMIT_M1) begin
                        state_d = ST_FORCE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end
            end

            ST_FORCE: begin
                // m_valid is guaranteed pending here. The gating keeps
                // m_ready and the write qualified by it regardless.
                sel_m       = m_valid;
                route_we    = m_valid;
                grant_m     = m_valid;
                force_stall = 1'b1;
                state_d     = ST_ARB;
                wait_cnt_d  = '0;
            end

            default: begin
                state_d    = ST_ARB;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign routed_zero = sel_m ? (m_waddr == 5'd0) : (p_waddr == 5'd0);

    // When no write reaches the register file, including a dropped x0 write,
    // the address and data buses show the pipeline inputs.
    always_comb begin
        m_ready   = 1'b0;
        stall_req = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        if (!rst) begin
            m_ready   = grant_m;
            stall_req = force_stall;
            rf_we     = route_we && !routed_zero;
            if (rf_we && sel_m) begin
                rf_waddr = m_waddr;
                rf_wdata = m_wdata;
            end else begin
                rf_waddr = p_waddr;
                rf_wdata = p_wdata;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        p_we;
    logic [4:0]  p_waddr;
    logic [31:0] p_wdata;
    logic        m_valid;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .p_we      (p_we),
        .p_waddr   (p_waddr),
        .p_wdata   (p_wdata),
        .m_valid   (m_valid),
        .m_waddr   (m_waddr),
        .m_wdata   (m_wdata),
        .m_ready   (m_ready),
        .stall_req (stall_req),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        mr;
        logic        st;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Monitor: compare each cycle's outputs against the queued expectation.
    // It also checks the bench's own stimulus against the m_valid protocol.
    logic prev_mv = 1'b0;
    logic prev_mr = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (m_ready !== e.mr || stall_req !== e.st || rf_we !== e.we ||
                rf_waddr !== e.wa || rf_wdata !== e.wd) begin
                miscompares++;
                $display("FAIL %s: got mr=%b st=%b we=%b wa=%0d wd=%h, want mr=%b st=%b we=%b wa=%0d wd=%h",
                         e.name, m_ready, stall_req, rf_we, rf_waddr, rf_wdata,
                         e.mr, e.st, e.we, e.wa, e.wd);
            end
        end
        if (prev_mv && !prev_mr && !m_valid && !rst) begin
            miscompares++;
            $display("FAIL protocol: m_valid dropped without handshake, got m_valid=0, want 1");
        end
        prev_mv = m_valid;
        prev_mr = m_ready;
    end

    task automatic step(input string name,
                        input logic r,
                        input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic mv,  input logic [4:0] ma, input logic [31:0] md,
                        input logic emr, input logic est, input logic ewe,
                        input logic [4:0] ewa, input logic [31:0] ewd);
        exp_t e;
        @(posedge clk);
        #1;
        rst     = r;
        p_we    = pwe;
        p_waddr = pa;
        p_wdata = pd;
        m_valid = mv;
        m_waddr = ma;
        m_wdata = md;
        e.name = name; e.mr = emr; e.st = est; e.we = ewe; e.wa = ewa; e.wd = ewd;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; p_we = 1'b0; p_waddr = '0; p_wdata = '0;
        m_valid = 1'b0; m_waddr = '0; m_wdata = '0;

        // Reset: outputs forced to 0 whatever the inputs say.
        step("reset_busy", 1, 1, 5'd5, 32'h1234_5678, 1, 5'd9, 32'h9999_9999, 0, 0, 0, 5'd0, 32'h0);
        step("reset_idle", 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 32'h0);

        // Basic routing.
        step("pipe_only", 0, 1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'h0, 0, 0, 1, 5'd5, 32'h1234_5678);
        step("mc_idle_pipe", 0, 0, 5'd3, 32'h0000_0011, 1, 5'd9, 32'hCAFE_0001, 1, 0, 1, 5'd9, 32'hCAFE_0001);
        step("neither", 0, 0, 5'd2, 32'h0000_0022, 0, 5'd0, 32'h0, 0, 0, 0, 5'd2, 32'h0000_0022);

        // Starvation: the pipeline wins cycles 0-3, and cycle 4 is forced.
        for (int unsigned i = 1; i <= 4; i++)
            step("starve_lost", 0, 1, 5'(i), 32'h100 + i, 1, 5'd20, 32'hDEAD_0020,
                 0, 0, 1, 5'(i), 32'h100 + i);
        step("starve_force", 0, 1, 5'd5, 32'h105, 1, 5'd20, 32'hDEAD_0020, 1, 1, 1, 5'd20, 32'hDEAD_0020);
        step("starve_held", 0, 1, 5'd5, 32'h105, 0, 5'd0, 32'h0, 0, 0, 1, 5'd5, 32'h105);
        step("starve_after", 0, 1, 5'd6, 32'h106, 0, 5'd0, 32'h0, 0, 0, 1, 5'd6, 32'h106);

        // Same-address collision: pipeline data wins, multi-cycle is retired.
        step("collide", 0, 1, 5'd7, 32'hAAAA, 1, 5'd7, 32'hBBBB, 1, 0, 1, 5'd7, 32'hAAAA);

        // Address zero: write suppressed, buses show pipeline inputs.
        step("mc_addr0", 0, 0, 5'd3, 32'h33, 1, 5'd0, 32'h55, 1, 0, 0, 5'd3, 32'h33);
        step("pipe_addr0", 0, 1, 5'd0, 32'h44, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 32'h44);

        // The counter was cleared by the collision and by the x0 grant. Three
        // lost cycles are not enough for a forced grant, so a free cycle grants.
        for (int unsigned i = 1; i <= 3; i++)
            step("partial_lost", 0, 1, 5'(10 + i), 32'h200 + i, 1, 5'd22, 32'h22,
                 0, 0, 1, 5'(10 + i), 32'h200 + i);
        step("partial_grant", 0, 0, 5'd14, 32'h204, 1, 5'd22, 32'h22, 1, 0, 1, 5'd22, 32'h22);

        // Reset during the FORCE cycle: the forced grant is abandoned.
        for (int unsigned i = 1; i <= 4; i++)
            step("rf_lost", 0, 1, 5'(i), 32'h300 + i, 1, 5'd21, 32'h77,
                 0, 0, 1, 5'(i), 32'h300 + i);
        step("rf_in_reset", 1, 1, 5'd5, 32'h305, 1, 5'd21, 32'h77, 0, 0, 0, 5'd0, 32'h0);
        for (int unsigned i = 6; i <= 9; i++)
            step("rf_relost", 0, 1, 5'(i), 32'h300 + i, 1, 5'd21, 32'h77,
                 0, 0, 1, 5'(i), 32'h300 + i);
        step("rf_force", 0, 1, 5'd10, 32'h30A, 1, 5'd21, 32'h77, 1, 1, 1, 5'd21, 32'h77);
        step("rf_held", 0, 1, 5'd10, 32'h30A, 0, 5'd0, 32'h0, 0, 0, 1, 5'd10, 32'h30A);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
